// File: rtl/axis_l2_addr_swap_if.sv
// 32-bit AXI4-Stream link (data, byte keep, last, single user bit) shared by the
// input and output ports of the L2 address swapper.
interface axis_l2_addr_swap_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_l2_addr_swap.sv
// Swaps the destination and source MAC addresses of each Ethernet frame on a
// 32-bit stream: buffers the 12-byte header, re-emits it, then cuts through.
module axis_l2_addr_swap #(
  parameter int unsigned ACT_BIT = 13
) (
  input  logic                       axis_tx_clk,
  input  logic                       axis_reset,
  input  logic                       swap_en,
  axis_l2_addr_swap_if.slave         s_axis,
  axis_l2_addr_swap_if.master        m_axis,
  output logic [15:0]                frame_count,
  output logic                       activity_flash
);
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned KEEP_W    = DATA_W / 8;
  localparam int unsigned HDR_BEATS = 3;
  localparam int unsigned CNT_W     = 16;
  localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  typedef enum logic [1:0] {COLLECT, EMIT, PASS} state_t;

  state_t             state_q, state_d;
  beat_t              hdr_q [HDR_BEATS];
  beat_t              hdr_d [HDR_BEATS];
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [1:0]         emit_idx_q, emit_idx_d;
  logic               swap_en_q, swap_en_d;
  logic               swap_act_q, swap_act_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               live_q;

  beat_t                      cur;
  beat_t                      in_beat;
  logic [HDR_BEATS*DATA_W-1:0] hdr_flat;
  logic [DATA_W-1:0]          sw_data [HDR_BEATS];
  logic                       s_fire, m_fire, sw_sel;

  assign cur      = hdr_q[emit_idx_q];
  assign in_beat  = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast, user: s_axis.tuser};
  assign hdr_flat = {hdr_q[2].data, hdr_q[1].data, hdr_q[0].data};

  // Header bytes 0..5 (dst) and 6..11 (src) exchanged, kept in wire byte order
  assign sw_data[0] = hdr_flat[79:48];
  assign sw_data[1] = {hdr_flat[15:0], hdr_flat[95:80]};
  assign sw_data[2] = hdr_flat[47:16];

  assign s_fire = s_axis.tvalid && s_axis.tready;
  assign m_fire = m_axis.tvalid && m_axis.tready;
  assign sw_sel = (hdr_cnt_q == 2'd0) ? swap_en : swap_en_q;

  assign frame_count    = frame_count_q;
  assign activity_flash = frame_count_q[ACT_BIT];

  // Port drive: buffered header in EMIT, straight wires in PASS
  always_comb begin
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tlast  = 1'b0;
    m_axis.tuser  = 1'b0;
    case (state_q)
      COLLECT: s_axis.tready = live_q;
      EMIT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = swap_act_q ? sw_data[emit_idx_q] : cur.data;
        m_axis.tkeep  = cur.keep;
        m_axis.tlast  = cur.last;
        m_axis.tuser  = cur.user;
      end
      PASS: begin
        s_axis.tready = m_axis.tready;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tlast  = s_axis.tlast;
        m_axis.tuser  = s_axis.tuser;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    hdr_cnt_d     = hdr_cnt_q;
    emit_idx_d    = emit_idx_q;
    swap_en_d     = swap_en_q;
    swap_act_d    = swap_act_q;
    frame_count_d = frame_count_q;

    if (m_fire && m_axis.tlast) frame_count_d = frame_count_q + CNT_W'(1);

    case (state_q)
      COLLECT: if (s_fire) begin
        hdr_d[hdr_cnt_q] = in_beat;
        if (hdr_cnt_q == 2'd0) swap_en_d = swap_en;
        if (hdr_cnt_q == HDR_LAST || s_axis.tlast) begin
          state_d    = EMIT;
          hdr_cnt_d  = 2'd0;
          emit_idx_d = 2'd0;
          // Only a full, fully-populated 12-byte header is rewritten
          swap_act_d = sw_sel && (hdr_cnt_q == HDR_LAST) && (hdr_q[0].keep == '1)
                       && (hdr_q[1].keep == '1) && (s_axis.tkeep == '1);
        end else begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
        end
      end
      EMIT: if (m_fire) begin
        if (cur.last)                     state_d = COLLECT;
        else if (emit_idx_q == HDR_LAST)  state_d = PASS;
        else                              emit_idx_d = emit_idx_q + 2'd1;
      end
      PASS: if (s_fire && s_axis.tlast) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge axis_tx_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q       <= COLLECT;
      hdr_q         <= '{default: '0};
      hdr_cnt_q     <= 2'd0;
      emit_idx_q    <= 2'd0;
      swap_en_q     <= 1'b0;
      swap_act_q    <= 1'b0;
      frame_count_q <= '0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      hdr_cnt_q     <= hdr_cnt_d;
      emit_idx_q    <= emit_idx_d;
      swap_en_q     <= swap_en_d;
      swap_act_q    <= swap_act_d;
      frame_count_q <= frame_count_d;
      live_q        <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_l2_addr_swap.sv
// Scoreboard bench for axis_l2_addr_swap: frames are modelled as byte lists with
// the two MAC addresses exchanged; a negedge monitor pops and compares.
module tb_axis_l2_addr_swap;
  localparam int unsigned ACT_BIT = 13;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        swap_en;
  logic [15:0] frame_count;
  logic        activity_flash;

  axis_l2_addr_swap_if s_if();
  axis_l2_addr_swap_if m_if();

  axis_l2_addr_swap #(.ACT_BIT(ACT_BIT)) dut (
    .axis_tx_clk    (clk),
    .axis_reset     (rst),
    .swap_en        (swap_en),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .frame_count    (frame_count),
    .activity_flash (activity_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    bp_en  = 1'b0;
  bit    gap_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.user = u;
    return b;
  endfunction

  // Reference: flatten to bytes, exchange dst MAC (0..5) with src MAC (6..11)
  function automatic void model_push(input beat_t f[$], input logic sw);
    logic [7:0] bytes[$];
    logic [7:0] t;
    beat_t      o;
    bit do_swap = sw && f.size() >= 3 && f[0].keep == 4'hF && f[1].keep == 4'hF && f[2].keep == 4'hF;
    for (int i = 0; i < f.size(); i++)
      for (int k = 0; k < 4; k++) bytes.push_back(f[i].data[8*k +: 8]);
    if (do_swap)
      for (int k = 0; k < 6; k++) begin
        t = bytes[k]; bytes[k] = bytes[k+6]; bytes[k+6] = t;
      end
    for (int i = 0; i < f.size(); i++) begin
      o = f[i];
      o.data = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      exp_q.push_back(o);
    end
  endfunction

  // Output ready: random under backpressure, else always 1
  always begin
    @(posedge clk);
    #1;
    m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Drivers change at posedge+1; the handshake is judged at the following negedge
  task automatic send_beat(input beat_t b, input logic sw);
    int  gap;
    int  budget;
    bit  acc;
    gap = (gap_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    s_if.tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tlast = b.last; s_if.tuser = b.user;
    swap_en = sw;
    s_if.tvalid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      if (acc) break;
      budget++;
      if (budget > 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=stalled required=accepted");
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drive_frame(input beat_t f[$], input logic sw, input bit vary_sw);
    for (int i = 0; i < f.size(); i++)
      send_beat(f[i], (i == 0 || !vary_sw) ? sw : 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50000) begin @(posedge clk); #1; n++; end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
    check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
    check({tag, "_m_tlast"},  32'(m_if.tlast),  32'd0);
    check({tag, "_m_tuser"},  32'(m_if.tuser),  32'd0);
    check({tag, "_m_tdata"},  m_if.tdata,       32'd0);
    check({tag, "_m_tkeep"},  32'(m_if.tkeep),  32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset_checks("rst");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: scoreboard pop, running frame counter and backpressure stability
  logic [15:0] exp_fc;
  bit          prev_stall;
  beat_t       prev_b;
  beat_t       e;
  always @(negedge clk) begin
    if (rst) begin
      exp_fc = 16'd0;
      prev_stall = 1'b0;
    end else begin
      check("frame_count_track", 32'(frame_count), 32'(exp_fc));
      check("activity_flash", 32'(activity_flash), 32'(exp_fc[ACT_BIT]));
      if (prev_stall) begin
        check("stall_valid", 32'(m_if.tvalid), 32'd1);
        check("stall_data", m_if.tdata, prev_b.data);
        check("stall_ctrl", {27'd0, m_if.tkeep, m_if.tlast, m_if.tuser},
              {27'd0, prev_b.keep, prev_b.last, prev_b.user});
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=0x%0h required=none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", m_if.tdata, e.data);
          check("out_tkeep", 32'(m_if.tkeep), 32'(e.keep));
          check("out_tlast", 32'(m_if.tlast), 32'(e.last));
          check("out_tuser", 32'(m_if.tuser), 32'(e.user));
        end
        if (m_if.tlast) exp_fc = exp_fc + 16'd1;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_b = mk(m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser);
    end
  end

  initial begin
    #(64'd5_000_000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t f[$];
    beat_t b;
    int    n;
    logic  sw;

    rst = 1'b1; swap_en = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset_checks("init");
    rst = 1'b0;
    #1 check("tready_after_deassert", 32'(s_if.tready), 32'd0);
    @(posedge clk); #1;
    check("tready_first_edge", 32'(s_if.tready), 32'd1);

    // 16-byte frame, swap on
    f = '{mk(32'h03020100, 4'hF, 1'b0, 1'b0), mk(32'h07060504, 4'hF, 1'b0, 1'b0),
          mk(32'h0B0A0908, 4'hF, 1'b0, 1'b1), mk(32'h0F0E0D0C, 4'hF, 1'b1, 1'b0)};
    exp_q.push_back(mk(32'h09080706, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h01000B0A, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h05040302, 4'hF, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h0F0E0D0C, 4'hF, 1'b1, 1'b0));
    drive_frame(f, 1'b1, 1'b0);
    drain("drain_swap16");
    check("fc_swap16", 32'(frame_count), 32'd1);

    // Same frame, swap off
    do_reset();
    foreach (f[i]) exp_q.push_back(f[i]);
    drive_frame(f, 1'b0, 1'b0);
    drain("drain_noswap16");
    check("fc_noswap16", 32'(frame_count), 32'd1);

    // 8-byte frame then 12-byte frame
    do_reset();
    f = '{mk(32'h03020100, 4'hF, 1'b0, 1'b0), mk(32'h07060504, 4'hF, 1'b1, 1'b0)};
    exp_q.push_back(f[0]);
    exp_q.push_back(f[1]);
    drive_frame(f, 1'b1, 1'b0);
    f = '{mk(32'h13121110, 4'hF, 1'b0, 1'b0), mk(32'h17161514, 4'hF, 1'b0, 1'b0),
          mk(32'h1B1A1918, 4'hF, 1'b1, 1'b0)};
    exp_q.push_back(mk(32'h19181716, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h11101B1A, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h15141312, 4'hF, 1'b1, 1'b0));
    drive_frame(f, 1'b1, 1'b0);
    drain("drain_short");
    check("fc_short", 32'(frame_count), 32'd2);

    // Randomized traffic with backpressure and input gaps
    do_reset();
    bp_en = 1'b1; gap_en = 1'b1;
    for (int fr = 0; fr < 1000; fr++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 64)) : int'($urandom_range(1, 8));
      f.delete();
      for (int i = 0; i < n; i++) begin
        b.data = $urandom;
        b.keep = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        b.last = (i == n - 1);
        b.user = 1'($urandom_range(0, 1));
        f.push_back(b);
      end
      sw = 1'($urandom_range(0, 1));
      model_push(f, sw);
      drive_frame(f, sw, 1'b1);
    end
    drain("drain_random");
    check("fc_random", 32'(frame_count), 32'd1000);
    bp_en = 1'b0; gap_en = 1'b0;

    // Reset in the middle of a frame
    do_reset();
    send_beat(mk(32'hAABBCCDD, 4'hF, 1'b0, 1'b0), 1'b1);
    send_beat(mk(32'h11223344, 4'hF, 1'b0, 1'b0), 1'b1);
    s_if.tdata = 32'h55667788; s_if.tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks("midrst");
    s_if.tvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    f.delete();
    for (int i = 0; i < 5; i++) f.push_back(mk($urandom, 4'hF, i == 4, 1'b0));
    model_push(f, 1'b1);
    drive_frame(f, 1'b1, 1'b0);
    drain("drain_midrst");
    check("fc_midrst", 32'(frame_count), 32'd1);

    // Counter wrap through 65536 single-beat frames
    do_reset();
    for (int fr = 0; fr < 65535; fr++) begin
      b = mk($urandom, 4'($urandom_range(1, 15)), 1'b1, 1'($urandom_range(0, 1)));
      exp_q.push_back(b);
      send_beat(b, 1'($urandom_range(0, 1)));
    end
    drain("drain_preload");
    check("fc_preload", 32'(frame_count), 32'hFFFF);
    check("flash_preload", 32'(activity_flash), 32'd1);
    b = mk(32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    exp_q.push_back(b);
    send_beat(b, 1'b1);
    drain("drain_wrap");
    check("fc_wrap", 32'(frame_count), 32'd0);
    check("flash_wrap", 32'(activity_flash), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_l2_addr_swap.md
AXIS_L2_ADDR_SWAP -- requirements
Module: axis_l2_addr_swap

Interface
REQ-001 Parameter: ACT_BIT, default 13, selects the frame-counter bit driven onto activity_flash (range 0..15).
REQ-002 axis_tx_clk  in  1  single clock for all logic.
REQ-003 axis_reset  in  1  asynchronous, active-high reset.
REQ-004 swap_en  in  1  when 1, swap the 6-byte dst and src MAC fields of each frame; sampled on the first accepted beat of a frame.
REQ-005 s_axis_tdata / s_axis_tkeep / s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  32/4/1/1/1  input frame stream; byte 0 is at [7:0].
REQ-006 s_axis_tready  out  1  input accept.
REQ-007 m_axis_tdata / m_axis_tkeep / m_axis_tvalid / m_axis_tlast / m_axis_tuser  out  32/4/1/1/1  output frame stream.
REQ-008 m_axis_tready  in  1  output accept.
REQ-009 frame_count  out  16  count of completed output frames.
REQ-010 activity_flash  out  1  equals frame_count[ACT_BIT].

Function
REQ-011 A beat is transferred only when tvalid and tready are both 1; this applies to both ports.
REQ-012 FSM states: COLLECT, EMIT, PASS.
REQ-013 COLLECT: s_axis_tready=1, m_axis_tvalid=0; accepted beats are stored in hdr[0..2] (tdata, tkeep, tlast, tuser per beat), and hdr_cnt increments.
REQ-014 COLLECT->EMIT when the third beat is accepted, or when a beat with tlast=1 is accepted with hdr_cnt<3 (short frame).
REQ-015 EMIT: s_axis_tready=0, m_axis_tvalid=1; the stored beats are output in order, one per m handshake; emission begins on the cycle after the COLLECT->EMIT transition.
REQ-016 Swap is active for a frame only if the sampled swap_en=1, three header beats were captured, and all three had tkeep=4'hF; otherwise the stored beats are output unmodified.
REQ-017 Swap byte mapping, with dst bytes D1..D6 = input bytes 0..5 and src bytes S1..S6 = input bytes 6..11: out beat0 = {S4,S3,S2,S1}; beat1 = {D2,D1,S6,S5}; beat2 = {D6,D5,D4,D3} (listed MSB..LSB).
REQ-018 In EMIT, tkeep, tlast and tuser are taken from the stored beat being output; tdata alone is subject to the swap.
REQ-019 EMIT->COLLECT after the stored beat with tlast=1 is accepted; EMIT->PASS after the third stored beat (tlast=0) is accepted.
REQ-020 PASS: combinational feed-through; m_axis_t* = s_axis_t*, s_axis_tready = m_axis_tready; PASS->COLLECT on an accepted beat with tlast=1.
REQ-021 Outputs hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 frame_count increments by 1 on each accepted output beat with tlast=1, and wraps 16'hFFFF->0.
REQ-023 A frame of exactly 12 bytes (tlast on the third beat) is swapped and emitted with tlast on out beat2, then returns to COLLECT.
REQ-024 A single-beat frame is emitted as one unmodified beat with tlast=1.
REQ-025 A change of swap_en mid-frame has no effect until the next frame's first beat.
REQ-026 No beat is dropped or duplicated; output beat count equals input beat count for every frame.

Reset
REQ-027 While axis_reset=1: FSM=COLLECT, hdr_cnt=0, stored beats cleared to 0, frame_count=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0.
REQ-028 s_axis_tready rises no earlier than the first clock edge after axis_reset deasserts.
REQ-029 Reset asserted mid-frame discards the partial frame; the next accepted beat is treated as the first beat of a new frame.

Verification
REQ-030 Bench: swap_en=1; 16-byte frame bytes 0x00..0x0F with m_axis_tready=1 -> output beats 0x09080706, 0x01000B0A, 0x05040302, 0x0F0E0D0C; tlast on beat 3 only; frame_count=1.
REQ-031 Bench: same frame with swap_en=0 -> output beats identical to input (0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C).
REQ-032 Bench: swap_en=1; 8-byte frame (tlast on beat1) -> two unmodified beats, tlast on beat1; then a 12-byte frame -> three swapped beats, tlast on beat2; frame_count=2.
REQ-033 Bench: random m_axis_tready (50%) and random s_axis_tvalid gaps over 1000 frames of 1..64 beats -> scoreboard matches the REQ-017 model, output stable under backpressure, frame_count=1000.
REQ-034 Bench: assert axis_reset during beat 2 of a frame, deassert, send a full frame -> no output from the aborted frame; new frame output correct; frame_count=1.
REQ-035 Bench: preload frame_count via 65535 single-beat frames, then one more frame -> frame_count wraps to 0; activity_flash tracks bit ACT_BIT throughout.
